gemm_job_sequencer: RTL and testbench

- Initiator/driver for the GEMM block: generates `cmd`, feeds activation rows and weights into it, and collects result rows from it.
- Accepts a job: one weight matrix plus `num_rows` activation rows on a valid/ready input stream.
- Runs one weight-write cycle, then streams rows, stalling the GEMM pipeline under back-pressure.
- Delivers exactly `num_rows` result rows on a valid/ready output stream. Sits between the host-side buffers and GEMM.

---
 rtl/gemm_job_sequencer.sv | 124 ++++++++++++
 tb/tb_gemm_job_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_job_sequencer.sv
// GEMM job sequencer: loads one weight matrix, streams activation rows through the
// array (with zero-row drain) and returns exactly num_rows result rows under back-pressure.
package GEMM_pkg;
  typedef enum logic [1:0] {
    CMD_NONE          = 2'd0,
    CMD_WRITE_WEIGHTS = 2'd1,
    CMD_STREAM        = 2'd2
  } command_t;
endpackage

module gemm_job_sequencer
  import GEMM_pkg::*;
#(
  parameter int SA_SIZE                = 4,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int ROW_CNT_W              = 16
) (
  input  logic                                                          clk,
  input  logic                                                          resetn,
  input  logic                                                          start,
  input  logic [ROW_CNT_W-1:0]                                          num_rows,
  input  logic [SA_SIZE-1:0][SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]   weights_in,
  output logic                                                          busy,
  output logic                                                          done,
  input  logic                                                          in_valid,
  output logic                                                          in_ready,
  input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]                in_data,
  output logic                                                          out_valid,
  input  logic                                                          out_ready,
  output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]                out_data,
  output logic [SA_SIZE-1:0][SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]   gemm_weight_inputs,
  output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]                gemm_activation_inputs,
  input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]                gemm_activation_outputs,
  output command_t                                                      gemm_cmd,
  input  logic                                                          gemm_output_valid
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FINISH} state_t;

  state_t                                                        state, state_nxt;
  logic [ROW_CNT_W-1:0]                                          rows_total;
  logic [ROW_CNT_W-1:0]                                          rows_fed;
  logic [ROW_CNT_W-1:0]                                          rows_out;
  logic [SA_SIZE-1:0][SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]   weight_reg;

  logic slot_free;
  logic feeding;
  logic feed_ok;
  logic stream_cyc;
  logic capture;
  logic in_hs;

  // The GEMM only advances on CMD_STREAM, so withholding it is a lossless stall.
  assign slot_free  = !out_valid || out_ready;
  assign feeding    = (rows_fed != rows_total);
  assign feed_ok    = feeding ? in_valid : 1'b1;
  assign stream_cyc = (state == STREAM) && slot_free && feed_ok && (rows_out != rows_total);
  assign capture    = stream_cyc && gemm_output_valid;
  assign in_ready   = (state == STREAM) && slot_free && feeding;
  assign in_hs      = in_valid && in_ready;

  assign busy               = (state != IDLE);
  assign done               = (state == FINISH);
  assign gemm_weight_inputs = weight_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt              = state;
    gemm_cmd               = CMD_NONE;
    gemm_activation_inputs = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        gemm_cmd  = CMD_WRITE_WEIGHTS;
        state_nxt = (rows_total == '0) ? FINISH : STREAM;
      end
      STREAM: begin
        if (stream_cyc) begin
          gemm_cmd = CMD_STREAM;
          if (feeding) gemm_activation_inputs = in_data;
        end
        if ((rows_out == rows_total) && slot_free) state_nxt = FINISH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rows_total <= '0;
      rows_fed   <= '0;
      rows_out   <= '0;
      weight_reg <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        rows_total <= num_rows;
        weight_reg <= weights_in;
        rows_fed   <= '0;
        rows_out   <= '0;
      end
      if (in_hs) rows_fed <= rows_fed + 1'b1;
      if (capture) begin
        out_data <= gemm_activation_outputs;
        rows_out <= rows_out + 1'b1;
      end
      if (capture)        out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gemm_job_sequencer.sv
// Directed bench for gemm_job_sequencer with a behavioural GEMM peer (fill counter,
// 2*SA_SIZE latency, hold on CMD_NONE) and a negedge monitor of commands and results.
module tb_gemm_job_sequencer;
  import GEMM_pkg::*;

  localparam int SA   = 4;
  localparam int W    = 8;
  localparam int RW   = 16;
  localparam int FILL = 2 * SA;
  localparam int MAXC = 200;

  logic                          clk = 1'b0;
  logic                          resetn = 1'b0;
  logic                          start = 1'b0;
  logic [RW-1:0]                 num_rows = '0;
  logic [SA-1:0][SA-1:0][W-1:0]  weights_in = '0;
  logic                          busy, done;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [SA-1:0][W-1:0]          in_data = '0;
  logic                          out_valid;
  logic                          out_ready = 1'b0;
  logic [SA-1:0][W-1:0]          out_data;
  logic [SA-1:0][SA-1:0][W-1:0]  gemm_weight_inputs;
  logic [SA-1:0][W-1:0]          gemm_activation_inputs;
  logic [SA-1:0][W-1:0]          gemm_activation_outputs;
  command_t                      gemm_cmd;
  logic                          gemm_output_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gemm_job_sequencer #(.SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(W), .ROW_CNT_W(RW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .num_rows(num_rows), .weights_in(weights_in),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .gemm_weight_inputs(gemm_weight_inputs), .gemm_activation_inputs(gemm_activation_inputs),
    .gemm_activation_outputs(gemm_activation_outputs), .gemm_cmd(gemm_cmd),
    .gemm_output_valid(gemm_output_valid)
  );

  function automatic logic [SA-1:0][W-1:0] gemm_ref(input logic [SA-1:0][W-1:0] a,
                                                    input logic [SA-1:0][SA-1:0][W-1:0] w);
    logic [SA-1:0][W-1:0] r;
    logic [W-1:0]         acc;
    for (int j = 0; j < SA; j++) begin
      acc = '0;
      for (int i = 0; i < SA; i++) acc = acc + a[i] * w[i][j];
      r[j] = acc;
    end
    return r;
  endfunction

  // Behavioural GEMM: result of the k-th streamed row appears once 2*SA rows have entered
  logic [SA-1:0][W-1:0]         hist [256];
  logic [SA-1:0][SA-1:0][W-1:0] gw = '0;
  int                           fill = 0;

  always @(posedge clk) begin
    if (gemm_cmd == CMD_WRITE_WEIGHTS) begin
      fill <= 0;
      gw   <= gemm_weight_inputs;
    end else if (gemm_cmd == CMD_STREAM && fill < 255) begin
      hist[fill] <= gemm_activation_inputs;
      fill       <= fill + 1;
    end
  end

  assign gemm_output_valid       = (fill >= FILL);
  assign gemm_activation_outputs = gemm_output_valid ? gemm_ref(hist[(fill >= FILL) ? fill - FILL : 0], gw) : '0;

  // Monitor
  int                   n_wr = 0, n_st = 0, n_done = 0, n_ov = 0;
  logic [SA-1:0][W-1:0] res_q [$];

  always @(negedge clk) begin
    if (resetn) begin
      if (gemm_cmd == CMD_WRITE_WEIGHTS) n_wr <= n_wr + 1;
      if (gemm_cmd == CMD_STREAM)        n_st <= n_st + 1;
      if (done)                          n_done <= n_done + 1;
      if (out_valid)                     n_ov <= n_ov + 1;
      if (out_valid && out_ready)        res_q.push_back(out_data);
    end
  end

  logic [SA-1:0][W-1:0]         rows [16];
  logic [SA-1:0][SA-1:0][W-1:0] ident, ident2;

  command_t             rec_cmd  [MAXC];
  logic                 rec_ir   [MAXC];
  logic                 rec_iv   [MAXC];
  logic                 rec_ov   [MAXC];
  logic                 rec_busy [MAXC];
  logic                 rec_done [MAXC];
  logic [SA-1:0][W-1:0] rec_od   [MAXC];
  int                   rec_fed  [MAXC];

  // Cycle 0 of the recording is the LOAD cycle following the accepted start.
  task automatic run_job(input int n, input logic [SA-1:0][SA-1:0][W-1:0] w,
                         input int in_mode, input int out_mode, input int abort_cyc,
                         input int sa, input int sb, output int cd);
    int idx;
    bit acc;
    idx = 0;
    cd  = -1;
    @(posedge clk); #1;
    start = 1'b1; num_rows = RW'(n); weights_in = w;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      if (c == abort_cyc) begin
        resetn = 1'b0;
        return;
      end
      in_valid  = (in_mode == 1) ? (c % 3 == 0) : 1'b1;
      in_data   = in_valid ? rows[idx % 16] : {SA{8'hEE}};
      out_ready = !(out_mode == 1 && c >= 11 && c < 21);
      if (c == sa || c == sb) begin
        start = 1'b1; num_rows = 16'd5; weights_in = '1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      rec_cmd[c]  = gemm_cmd;
      rec_ir[c]   = in_ready;
      rec_iv[c]   = in_valid;
      rec_ov[c]   = out_valid;
      rec_od[c]   = out_data;
      rec_busy[c] = busy;
      rec_done[c] = done;
      rec_fed[c]  = idx;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (rec_done[c]) begin
        cd = c;
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int cd, d0, r0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (gemm_cmd !== CMD_NONE) begin errors++; $display("FAIL rst_cmd: got %0d want 0", gemm_cmd); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    checks++; if (gemm_weight_inputs !== '0) begin errors++; $display("FAIL rst_weights: got %h want 0", gemm_weight_inputs); end
    @(posedge clk); #1;
    resetn = 1'b1;
    d0 = n_done;
    run_job(5, ident, 0, 0, 12, -1, -1, cd);
    checks++; if (rec_ov[11] !== 1'b1) begin errors++; $display("FAIL abort_pending_ov: got %b want 1", rec_ov[11]); end
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
    checks++; if (gemm_cmd !== CMD_NONE) begin errors++; $display("FAIL abort_cmd: got %0d want 0", gemm_cmd); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (n_done !== d0) begin errors++; $display("FAIL abort_no_done: got %0d want %0d", n_done, d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy: got %b want 0", busy); end
    r0 = res_q.size();
    run_job(3, ident, 0, 0, -1, -1, -1, cd);
    checks++; if (cd !== 13) begin errors++; $display("FAIL post_rst_done_cycle: got %0d want 13", cd); end
    checks++; if (res_q.size() - r0 !== 3) begin errors++; $display("FAIL post_rst_count: got %0d want 3", res_q.size() - r0); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (res_q[r0 + k] !== rows[k]) begin errors++; $display("FAIL post_rst_row%0d: got %h want %h", k, res_q[r0 + k], rows[k]); end
    end
  endtask

  task automatic test_basic();
    int cd, w0, s0, d0, r0;
    w0 = n_wr; s0 = n_st; d0 = n_done; r0 = res_q.size();
    run_job(3, ident, 0, 0, -1, -1, -1, cd);
    checks++; if (cd !== 13) begin errors++; $display("FAIL basic_done_cycle: got %0d want 13", cd); end
    checks++; if (rec_cmd[0] !== CMD_WRITE_WEIGHTS) begin errors++; $display("FAIL basic_load_cmd: got %0d want 1", rec_cmd[0]); end
    checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL basic_wr_cycles: got %0d want 1", n_wr - w0); end
    checks++; if (n_st - s0 !== 11) begin errors++; $display("FAIL basic_stream_cycles: got %0d want 11", n_st - s0); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", n_done - d0); end
    checks++; if (rec_ov[9] !== 1'b0 || rec_ov[10] !== 1'b1) begin errors++; $display("FAIL basic_latency: got ov9=%b ov10=%b want 0 1", rec_ov[9], rec_ov[10]); end
    checks++; if (rec_busy[0] !== 1'b1 || rec_busy[13] !== 1'b1) begin errors++; $display("FAIL basic_busy_window: got %b %b want 1 1", rec_busy[0], rec_busy[13]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    checks++; if (res_q.size() - r0 !== 3) begin errors++; $display("FAIL basic_count: got %0d want 3", res_q.size() - r0); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (res_q[r0 + k] !== gemm_ref(rows[k], ident)) begin errors++; $display("FAIL basic_row%0d: got %h want %h", k, res_q[r0 + k], gemm_ref(rows[k], ident)); end
    end
  endtask

  task automatic test_zero_len();
    int cd, w0, s0, v0;
    w0 = n_wr; s0 = n_st; v0 = n_ov;
    run_job(0, ident, 0, 0, -1, -1, -1, cd);
    checks++; if (cd !== 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want 1", cd); end
    checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL zero_wr_cycles: got %0d want 1", n_wr - w0); end
    checks++; if (n_st - s0 !== 0) begin errors++; $display("FAIL zero_stream_cycles: got %0d want 0", n_st - s0); end
    checks++; if (n_ov - v0 !== 0) begin errors++; $display("FAIL zero_out_valid: got %0d want 0", n_ov - v0); end
  endtask

  task automatic test_starvation();
    int cd, s0, r0;
    s0 = n_st; r0 = res_q.size();
    run_job(5, ident, 1, 0, -1, -1, -1, cd);
    checks++; if (cd < 0) begin errors++; $display("FAIL starve_timeout: got %0d want done", cd); end
    for (int c = 1; c < cd; c++) begin
      if (!rec_iv[c] && rec_fed[c] < 5) begin
        checks++;
        if (rec_cmd[c] !== CMD_NONE) begin errors++; $display("FAIL starve_cmd_c%0d: got %0d want 0", c, rec_cmd[c]); end
      end
    end
    checks++; if (n_st - s0 !== 13) begin errors++; $display("FAIL starve_stream_cycles: got %0d want 13", n_st - s0); end
    checks++; if (res_q.size() - r0 !== 5) begin errors++; $display("FAIL starve_count: got %0d want 5", res_q.size() - r0); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (res_q[r0 + k] !== rows[k]) begin errors++; $display("FAIL starve_row%0d: got %h want %h", k, res_q[r0 + k], rows[k]); end
    end
  endtask

  task automatic test_backpressure();
    int cd, s0, r0, bad;
    s0 = n_st; r0 = res_q.size();
    run_job(12, ident, 0, 1, -1, -1, -1, cd);
    checks++; if (cd < 0) begin errors++; $display("FAIL bp_timeout: got %0d want done", cd); end
    for (int c = 11; c < 21; c++) begin
      bad = 0;
      if (rec_ov[c] !== 1'b1) bad = 1;
      if (rec_od[c] !== rows[1]) bad = 1;
      if (rec_ir[c] !== 1'b0) bad = 1;
      if (rec_cmd[c] === CMD_STREAM) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL bp_stall_c%0d: got ov=%b data=%h in_ready=%b cmd=%0d want ov=1 data=%h in_ready=0 cmd!=2",
                 c, rec_ov[c], rec_od[c], rec_ir[c], rec_cmd[c], rows[1]);
      end
    end
    checks++; if (n_st - s0 !== 20) begin errors++; $display("FAIL bp_stream_cycles: got %0d want 20", n_st - s0); end
    checks++; if (res_q.size() - r0 !== 12) begin errors++; $display("FAIL bp_count: got %0d want 12", res_q.size() - r0); end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (res_q[r0 + k] !== rows[k]) begin errors++; $display("FAIL bp_row%0d: got %h want %h", k, res_q[r0 + k], rows[k]); end
    end
  endtask

  task automatic test_busy_start();
    int cd, s0, r0, d0;
    s0 = n_st; r0 = res_q.size(); d0 = n_done;
    run_job(3, ident2, 0, 0, -1, 3, 13, cd);
    checks++; if (cd !== 13) begin errors++; $display("FAIL busy_start_done_cycle: got %0d want 13", cd); end
    checks++; if (n_st - s0 !== 11) begin errors++; $display("FAIL busy_start_stream_cycles: got %0d want 11", n_st - s0); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", n_done - d0); end
    checks++; if (busy !== 1'b0 || gemm_cmd !== CMD_NONE) begin errors++; $display("FAIL busy_start_relaunch: got busy=%b cmd=%0d want 0 0", busy, gemm_cmd); end
    checks++; if (gemm_weight_inputs !== ident2) begin errors++; $display("FAIL busy_start_weights: got %h want %h", gemm_weight_inputs, ident2); end
    checks++; if (res_q.size() - r0 !== 3) begin errors++; $display("FAIL busy_start_count: got %0d want 3", res_q.size() - r0); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (res_q[r0 + k] !== gemm_ref(rows[k], ident2)) begin errors++; $display("FAIL busy_start_row%0d: got %h want %h", k, res_q[r0 + k], gemm_ref(rows[k], ident2)); end
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < SA; i++) rows[k][i] = W'(4 * k + i + 1);
    ident = '0; ident2 = '0;
    for (int i = 0; i < SA; i++) begin
      ident[i][i]  = 8'd1;
      ident2[i][i] = 8'd2;
    end
    test_reset();
    test_basic();
    test_zero_len();
    test_starvation();
    test_backpressure();
    test_busy_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
